uart_reg_controller: RTL and testbench
======================================

// Module: uart_reg_controller
// PURPOSE
// Sequences the UART byte datapath into a register-access protocol for the control computer.
// Consumes bytes from UARTReceiver (data/drdy) and decodes 1- or 2-byte commands.
// Performs single-cycle register-bus reads/writes, then returns one response byte through UARTTransmitter.
// Sits in UniboardTop between the UART pair and the peripheral register file (steppers, PWM, LEDs).
// PARAMETERS
// TIMEOUT_CYCLES  208300  max clk cycles from header drdy to data drdy (10 byte times at div 2083); expiry -> NAK
// ACK_BYTE        8'h06   response to a completed write
// NAK_BYTE        8'h15   response to a timed-out write
// PORTS
// clk            in   1  system clock (clk_20MHz)
// reset          in   1  synchronous, active-high reset
// rx_data        in   8  received byte, valid when rx_drdy=1
// rx_drdy        in   1  one-cycle pulse per received byte
// tx_data        out  8  byte to transmit, held stable while tx_send=1
// tx_send        out  1  one-cycle transmit request
// tx_busy        in   1  transmitter busy; high from cycle after tx_send until stop bit ends
// reg_addr       out  7  register address
// reg_wdata      out  8  register write data
// reg_we         out  1  one-cycle write strobe
// reg_re         out  1  one-cycle read strobe
// reg_rdata      in   8  read data, valid the cycle after reg_re
// busy           out  1  high in any state other than IDLE
// overrun_count  out  8  bytes dropped while not accepting, saturates at 8'hFF
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-command abandons it with no response.
//   A byte already in flight in the transmitter is not aborted.
// - Header byte: bit7=1 write, bit7=0 read; bits[6:0] = address.
// - Write = header + data byte -> ACK_BYTE. Read = header only -> reg_rdata byte.
// - States: IDLE, WAIT_DATA, DO_WRITE, DO_READ, CAPTURE, TX_REQ, TX_WAIT.
// - IDLE: on rx_drdy, latch reg_addr<=rx_data[6:0].
//   - bit7=1: go to WAIT_DATA, clear timer.
//   - bit7=0: go to DO_READ.
// - WAIT_DATA: timer increments each cycle.
//   - On rx_drdy: reg_wdata<=rx_data, go to DO_WRITE.
//   - Else if timer reaches TIMEOUT_CYCLES-1: tx_data<=NAK_BYTE, go to TX_REQ.
//   - rx_drdy in the expiry cycle counts as the data byte.
// - DO_WRITE: reg_we=1 for exactly this cycle; tx_data<=ACK_BYTE; go to TX_REQ.
// - DO_READ: reg_re=1 for exactly this cycle; go to CAPTURE.
// - CAPTURE: tx_data<=reg_rdata; go to TX_REQ.
// - TX_REQ: if tx_busy=0, tx_send=1 for exactly this cycle, go to TX_WAIT; else hold.
// - TX_WAIT: skip the first cycle, then go to IDLE when tx_busy=0.
// - Latency, read: header drdy cycle T -> reg_re T+1 -> capture T+2 -> tx_send T+3 (tx idle).
// - Latency, write: data drdy T -> reg_we T+1 -> tx_send T+2 (tx idle).
// - Accepting states: only IDLE and WAIT_DATA accept bytes.
//   rx_drdy in any other state drops the byte and increments overrun_count (saturating).
// - reg_addr/reg_wdata hold their last value between commands; strobes never overlap; tx_data is stable from TX_REQ to IDLE.
// TESTING
// 1. Write: rx 8'h85 then 8'h3C -> reg_we one cycle, addr=7'h05, wdata=8'h3C; tx_send once with tx_data=8'h06.
// 2. Read: rx 8'h12 with reg_rdata=8'hA7 -> reg_re one cycle at addr=7'h12; tx_send at T+3, tx_data=8'hA7.
// 3. Timeout: rx 8'h81, no further byte -> after TIMEOUT_CYCLES, tx_data=8'h15, tx_send once, reg_we never set.
//    Variant: data byte arrives on the expiry cycle -> normal write, ACK.
// 4. Overrun: rx a byte during TX_WAIT -> dropped, overrun_count 0->1.
//    Force 300 drops -> count stays 8'hFF.
// 5. Backpressure: tx_busy held 1 for 500 cycles at TX_REQ -> tx_send withheld, then fires once the cycle tx_busy falls.
// 6. Reset mid-command: assert reset in WAIT_DATA -> next cycle busy=0, all outputs 0, no tx_send;
//    then a fresh read command completes normally.

Source files
------------

// File: rtl/uart_reg_controller.sv
// uart_reg_controller
// Turns the UART byte stream into register accesses. It decodes 1-byte read
// commands and 2-byte write commands, drives a single-cycle register bus
// strobe, and returns one response byte to the transmitter.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   rx_data, rx_drdy    received byte and its one-cycle valid pulse
//   tx_data, tx_send    response byte and one-cycle transmit request
//   tx_busy             transmitter busy
//   reg_addr, reg_wdata register bus address and write data
//   reg_we, reg_re      one-cycle write/read strobes
//   reg_rdata           read data, valid the cycle after reg_re
//   busy                controller is handling a command
//   overrun_count       saturating count of bytes dropped while not accepting
module uart_reg_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 208300,
   parameter logic [7:0]  ACK_BYTE       = 8'h06,
   parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_drdy,
   output logic [7:0] tx_data,
   output logic       tx_send,
   input  logic       tx_busy,
   output logic [6:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic [7:0] overrun_count
);

   localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WAIT_DATA, ST_DO_WRITE, ST_DO_READ, ST_CAPTURE, ST_TX_REQ, ST_TX_WAIT
   } state_e;

   state_e           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             skip_q, skip_d;
   logic [6:0]       reg_addr_q, reg_addr_d;
   logic [7:0]       reg_wdata_q, reg_wdata_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic [7:0]       overrun_q, overrun_d;
   logic             reg_we_q, reg_we_d;
   logic             reg_re_q, reg_re_d;
   logic             busy_q, busy_d;
   logic             tx_send_c;
   logic             accept_c;

   // Next-state, datapath and strobe decode
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      skip_d      = skip_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      tx_data_d   = tx_data_q;
      overrun_d   = overrun_q;
      tx_send_c   = 1'b0;
      accept_c    = (state_q == ST_IDLE) || (state_q == ST_WAIT_DATA);

      if (rx_drdy && !accept_c && (overrun_q != 8'hFF)) begin
         overrun_d = overrun_q + 8'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (rx_drdy) begin
               reg_addr_d = rx_data[6:0];
               if (rx_data[7]) begin
                  state_d = ST_WAIT_DATA;
                  timer_d = '0;
               end else begin
                  state_d = ST_DO_READ;
               end
            end
         end
         ST_WAIT_DATA: begin
            // A data byte on the expiry cycle still wins over the timeout
            if (rx_drdy) begin
               reg_wdata_d = rx_data;
               state_d     = ST_DO_WRITE;
            end else if (timer_q == TMR_LAST) begin
               tx_data_d = NAK_BYTE;
               state_d   = ST_TX_REQ;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_DO_WRITE: begin
            tx_data_d = ACK_BYTE;
            state_d   = ST_TX_REQ;
         end
         ST_DO_READ: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            tx_data_d = reg_rdata;
            state_d   = ST_TX_REQ;
         end
         ST_TX_REQ: begin
            if (!tx_busy) begin
               tx_send_c = 1'b1;
               skip_d    = 1'b1;
               state_d   = ST_TX_WAIT;
            end
         end
         ST_TX_WAIT: begin
            // tx_busy only rises the cycle after tx_send, so ignore the first cycle
            if (skip_q) begin
               skip_d = 1'b0;
            end else if (!tx_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Strobes are registered from the next state so they line up with it
      reg_we_d = (state_d == ST_DO_WRITE);
      reg_re_d = (state_d == ST_DO_READ);
      busy_d   = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         skip_q      <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         tx_data_q   <= '0;
         overrun_q   <= '0;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         skip_q      <= skip_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         tx_data_q   <= tx_data_d;
         overrun_q   <= overrun_d;
         reg_we_q    <= reg_we_d;
         reg_re_q    <= reg_re_d;
         busy_q      <= busy_d;
      end
   end

   // tx_send must respond in the same cycle tx_busy falls
   assign tx_send       = tx_send_c;
   assign tx_data       = tx_data_q;
   assign reg_addr      = reg_addr_q;
   assign reg_wdata     = reg_wdata_q;
   assign reg_we        = reg_we_q;
   assign reg_re        = reg_re_q;
   assign busy          = busy_q;
   assign overrun_count = overrun_q;

endmodule

// File: tb/tb_uart_reg_controller.sv
// Testbench for uart_reg_controller: directed timing sequences, a command
// vector table, and randomized commands scored against a transaction model.
module tb_uart_reg_controller;

   localparam int unsigned TO = 40;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_drdy;
   logic [7:0] tx_data;
   logic       tx_send;
   logic       tx_busy;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata = 8'h00;
   logic       busy;
   logic [7:0] overrun_count;

   uart_reg_controller #(
      .TIMEOUT_CYCLES(TO),
      .ACK_BYTE(8'h06),
      .NAK_BYTE(8'h15)
   ) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_drdy(rx_drdy),
      .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
      .reg_rdata(reg_rdata), .busy(busy), .overrun_count(overrun_count)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int fails     = 0;

   // Transmitter model: busy for tx_len cycles after each send, plus a force
   logic force_busy = 1'b0;
   int   tx_cnt = 0;
   int   tx_len = 6;
   assign tx_busy = force_busy | (tx_cnt != 0);
   always @(posedge clk) begin
      if (reset)            tx_cnt <= 0;
      else if (tx_send)     tx_cnt <= tx_len;
      else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
   end

   // Peripheral register file
   logic [7:0] mem [128];
   logic       pl_en = 1'b0;
   logic [6:0] pl_a  = 7'h00;
   logic [7:0] pl_v  = 8'h00;
   always @(posedge clk) begin
      if (pl_en)       mem[pl_a] <= pl_v;
      else if (reg_we) mem[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= mem[reg_addr];
   end

   // Event logs
   logic [7:0]  txq [$];
   logic [14:0] weq [$];
   logic [6:0]  req [$];
   int          overlap_n = 0;
   always @(posedge clk) begin
      if (!reset) begin
         if (tx_send) txq.push_back(tx_data);
         if (reg_we)  weq.push_back({reg_addr, reg_wdata});
         if (reg_re)  req.push_back(reg_addr);
         if (reg_we && reg_re) overlap_n <= overlap_n + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) cyc();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_drdy = 1'b1;
      cyc();
      rx_drdy = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic preload(input logic [6:0] a, input logic [7:0] v);
      pl_en = 1'b1; pl_a = a; pl_v = v;
      cyc();
      pl_en = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 4000) begin
         cyc();
         n++;
      end
      chk({nm, "_idle"}, 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic [7:0] hdr;
      logic [7:0] dat;
      logic       pre;
      logic [7:0] pre_val;
      logic [7:0] exp_tx;
      logic       exp_we;
      logic [6:0] exp_addr;
      logic [7:0] exp_wd;
   } vec_t;

   vec_t       vecs [8];
   logic [7:0] model_mem [128];
   int         exp_ovr;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nt, nw, nr;
      logic       is_w, stray;
      logic [6:0] a;
      logic [7:0] d, exp_tx;
      int         gap;

      vecs[0] = '{8'h85, 8'h3C, 1'b0, 8'h00, 8'h06, 1'b1, 7'h05, 8'h3C};
      vecs[1] = '{8'h05, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b0, 7'h05, 8'h00};
      vecs[2] = '{8'h12, 8'h00, 1'b1, 8'hA7, 8'hA7, 1'b0, 7'h12, 8'h00};
      vecs[3] = '{8'hFF, 8'h00, 1'b0, 8'h00, 8'h06, 1'b1, 7'h7F, 8'h00};
      vecs[4] = '{8'h7F, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 7'h7F, 8'h00};
      vecs[5] = '{8'h80, 8'hFF, 1'b0, 8'h00, 8'h06, 1'b1, 7'h00, 8'hFF};
      vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 7'h00, 8'h00};
      vecs[7] = '{8'h2A, 8'h00, 1'b1, 8'h5A, 8'h5A, 1'b0, 7'h2A, 8'h00};

      reset   = 1'b1;
      rx_drdy = 1'b0;
      rx_data = 8'h00;
      for (int i = 0; i < 128; i++) begin
         d = 8'($urandom);
         model_mem[i] = d;
         preload(7'(i), d);
      end

      // Reset state
      chk("rst_busy",    32'(busy), 32'd0);
      chk("rst_tx_send", 32'(tx_send), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_addr",    32'(reg_addr), 32'd0);
      chk("rst_wdata",   32'(reg_wdata), 32'd0);
      chk("rst_strobes", 32'({reg_we, reg_re}), 32'd0);
      chk("rst_ovr",     32'(overrun_count), 32'd0);
      reset = 1'b0;
      exp_ovr = 0;
      cyc();

      // Write with cycle-exact latency
      nt = txq.size(); nw = weq.size();
      send_byte(8'h85);
      chk("w_busy", 32'(busy), 32'd1);
      chk("w_hdr_addr", 32'(reg_addr), 32'h05);
      idle_cycles(2);
      send_byte(8'h3C);
      chk("w_we", 32'(reg_we), 32'd1);
      chk("w_wdata", 32'(reg_wdata), 32'h3C);
      chk("w_addr", 32'(reg_addr), 32'h05);
      chk("w_send_early", 32'(tx_send), 32'd0);
      cyc();
      chk("w_we_one_cycle", 32'(reg_we), 32'd0);
      chk("w_send", 32'(tx_send), 32'd1);
      chk("w_ack", 32'(tx_data), 32'h06);
      wait_idle("w");
      chk("w_tx_count", 32'(txq.size() - nt), 32'd1);
      chk("w_we_count", 32'(weq.size() - nw), 32'd1);

      // Read with cycle-exact latency
      preload(7'h12, 8'hA7);
      nt = txq.size(); nr = req.size();
      send_byte(8'h12);
      chk("r_re", 32'(reg_re), 32'd1);
      chk("r_addr", 32'(reg_addr), 32'h12);
      chk("r_send_t1", 32'(tx_send), 32'd0);
      cyc();
      chk("r_re_one_cycle", 32'(reg_re), 32'd0);
      chk("r_send_t2", 32'(tx_send), 32'd0);
      cyc();
      chk("r_send_t3", 32'(tx_send), 32'd1);
      chk("r_data", 32'(tx_data), 32'hA7);
      wait_idle("r");
      chk("r_tx_count", 32'(txq.size() - nt), 32'd1);
      chk("r_re_count", 32'(req.size() - nr), 32'd1);

      // Timeout -> NAK
      nt = txq.size(); nw = weq.size();
      send_byte(8'h81);
      idle_cycles(TO - 1);
      chk("to_no_send_yet", 32'(tx_send), 32'd0);
      chk("to_still_busy", 32'(busy), 32'd1);
      cyc();
      chk("to_send", 32'(tx_send), 32'd1);
      chk("to_nak", 32'(tx_data), 32'h15);
      wait_idle("to");
      chk("to_no_we", 32'(weq.size() - nw), 32'd0);
      chk("to_tx_count", 32'(txq.size() - nt), 32'd1);

      // Data byte on the expiry cycle is a normal write
      send_byte(8'h83);
      idle_cycles(TO - 1);
      send_byte(8'h5E);
      chk("tov_we", 32'(reg_we), 32'd1);
      chk("tov_wdata", 32'(reg_wdata), 32'h5E);
      chk("tov_addr", 32'(reg_addr), 32'h03);
      cyc();
      chk("tov_send", 32'(tx_send), 32'd1);
      chk("tov_ack", 32'(tx_data), 32'h06);
      wait_idle("tov");

      // Overrun during TX_WAIT, then saturation
      send_byte(8'h20);
      idle_cycles(3);
      force_busy = 1'b1;
      send_byte(8'h99);
      exp_ovr = 1;
      chk("ovr_one", 32'(overrun_count), 32'(exp_ovr));
      for (int i = 0; i < 300; i++) send_byte(8'($urandom));
      exp_ovr = 255;
      chk("ovr_sat", 32'(overrun_count), 32'(exp_ovr));
      chk("ovr_still_busy", 32'(busy), 32'd1);
      force_busy = 1'b0;
      wait_idle("ovr");

      // Backpressure at TX_REQ
      nt = txq.size();
      force_busy = 1'b1;
      send_byte(8'h12);
      idle_cycles(2);
      idle_cycles(500);
      chk("bp_withheld", 32'(txq.size() - nt), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      force_busy = 1'b0;
      #1;
      chk("bp_fire", 32'(tx_send), 32'd1);
      chk("bp_data", 32'(tx_data), 32'hA7);
      cyc();
      chk("bp_once", 32'(tx_send), 32'd0);
      wait_idle("bp");
      chk("bp_tx_count", 32'(txq.size() - nt), 32'd1);

      // Reset mid-command
      send_byte(8'h81);
      idle_cycles(3);
      nt = txq.size();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      exp_ovr = 0;
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_outs", 32'({tx_data, reg_addr, reg_wdata, reg_we, reg_re, tx_send}), 32'd0);
      chk("mr_ovr", 32'(overrun_count), 32'd0);
      idle_cycles(TO + 10);
      chk("mr_no_tx", 32'(txq.size() - nt), 32'd0);
      nr = req.size();
      send_byte(8'h12);
      wait_idle("mr_read");
      chk("mr_read_count", 32'(txq.size() - nt), 32'd1);
      if (txq.size() > nt) chk("mr_read_data", 32'(txq[nt]), 32'hA7);
      chk("mr_re_count", 32'(req.size() - nr), 32'd1);

      // Vector table
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].pre) preload(vecs[i].hdr[6:0], vecs[i].pre_val);
         nt = txq.size(); nw = weq.size(); nr = req.size();
         send_byte(vecs[i].hdr);
         if (vecs[i].hdr[7]) begin
            idle_cycles(1);
            send_byte(vecs[i].dat);
         end
         wait_idle($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_tx_count", i), 32'(txq.size() - nt), 32'd1);
         if (txq.size() > nt) chk($sformatf("vec%0d_tx", i), 32'(txq[nt]), 32'(vecs[i].exp_tx));
         chk($sformatf("vec%0d_addr", i), 32'(reg_addr), 32'(vecs[i].exp_addr));
         if (vecs[i].exp_we) begin
            chk($sformatf("vec%0d_we_count", i), 32'(weq.size() - nw), 32'd1);
            if (weq.size() > nw)
               chk($sformatf("vec%0d_we", i), 32'(weq[nw]), 32'({vecs[i].exp_addr, vecs[i].exp_wd}));
         end else begin
            chk($sformatf("vec%0d_re_count", i), 32'(req.size() - nr), 32'd1);
         end
      end

      // Randomized commands against the transaction model
      for (int i = 0; i < 128; i++) begin
         d = 8'($urandom);
         model_mem[i] = d;
         preload(7'(i), d);
      end
      for (int k = 0; k < 60; k++) begin
         tx_len = $urandom_range(1, 12);
         is_w = 1'($urandom_range(0, 1));
         a    = 7'($urandom);
         d    = 8'($urandom);
         nt = txq.size(); nw = weq.size(); nr = req.size();
         send_byte({is_w, a});
         if (is_w) begin
            gap = $urandom_range(0, TO + 3);
            if (gap < TO) begin
               idle_cycles(gap);
               send_byte(d);
               model_mem[a] = d;
               exp_tx = 8'h06;
            end else begin
               exp_tx = 8'h15;
            end
         end else begin
            exp_tx = model_mem[a];
            stray = 1'($urandom_range(0, 1));
            if (stray) begin
               send_byte(8'($urandom));
               if (exp_ovr < 255) exp_ovr++;
            end
         end
         wait_idle("rnd");
         chk("rnd_tx_count", 32'(txq.size() - nt), 32'd1);
         if (txq.size() > nt) chk("rnd_tx", 32'(txq[nt]), 32'(exp_tx));
         if (is_w && exp_tx == 8'h06) begin
            chk("rnd_we_count", 32'(weq.size() - nw), 32'd1);
            if (weq.size() > nw) chk("rnd_we", 32'(weq[nw]), 32'({a, d}));
         end else begin
            chk("rnd_we_none", 32'(weq.size() - nw), 32'd0);
         end
         chk("rnd_re_count", 32'(req.size() - nr), 32'(is_w ? 0 : 1));
         chk("rnd_ovr", 32'(overrun_count), 32'(exp_ovr));
      end

      chk("strobe_overlap", 32'(overlap_n), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
